// File: rtl/adc_multi_decimator.sv
// adc_multi_decimator
//   N-channel ADC decimator placed between the ADC capture front end and the
//   acquisition buffer. It collects N = max(PRESCALER_VALUE,1) accepted samples
//   per window. For each channel it emits the last sample, the window max, the
//   window min or the window sum, selected by MODE. The result is held on a
//   valid/ready output.
//
//   Ports
//     SYS_CLK          in   rising-edge clock
//     RESET            in   synchronous, active-high reset
//     ENABLE           in   0 aborts the current window and holds the block idle
//     IN_VALID         in   DATA_IN accepted this cycle (no input backpressure)
//     DATA_IN          in   packed samples, ch0 in [DATA_W-1:0]
//     PRESCALER_VALUE  in   decimation ratio, 0 treated as 1
//     MODE             in   0=SAMPLE 1=MAX 2=MIN 3=SUM
//     DATA_OUT         out  packed results, ch0 in [ACC_W-1:0]
//     DATA_VALID       out  DATA_OUT holds an unconsumed result
//     DATA_READY       in   downstream accepts DATA_OUT
//     OVERRUN          out  sticky flag, an unconsumed result was overwritten
//     CLR_OVERRUN      in   clears OVERRUN (an overwrite on the same edge wins)
//     OVERRUN_CNT      out  saturating overwrite counter, present only when
//                           ADC_DECIM_OVERRUN_CNT_EN is defined
module adc_multi_decimator #(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 14,
  parameter int RATIO_W = 7
) (
  input  logic                               SYS_CLK,
  input  logic                               RESET,
  input  logic                               ENABLE,
  input  logic                               IN_VALID,
  input  logic [NUM_CH*DATA_W-1:0]           DATA_IN,
  input  logic [RATIO_W-1:0]                 PRESCALER_VALUE,
  input  logic [1:0]                         MODE,
  output logic [NUM_CH*(DATA_W+RATIO_W)-1:0] DATA_OUT,
  output logic                               DATA_VALID,
  input  logic                               DATA_READY,
  output logic                               OVERRUN,
  input  logic                               CLR_OVERRUN
`ifdef ADC_DECIM_OVERRUN_CNT_EN
  ,
  output logic [15:0]                        OVERRUN_CNT
`endif
);

  localparam int ACC_W = DATA_W + RATIO_W;
  localparam logic [RATIO_W-1:0] ONE = {{(RATIO_W-1){1'b0}}, 1'b1};

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  localparam logic [1:0] M_SAMPLE = 2'd0;
  localparam logic [1:0] M_MAX    = 2'd1;
  localparam logic [1:0] M_MIN    = 2'd2;

  logic [0:0]              state;
  logic [RATIO_W-1:0]      cnt;
  logic [RATIO_W-1:0]      n_lat;
  logic [RATIO_W-1:0]      n_in;
  logic [RATIO_W-1:0]      n_eff;
  logic [1:0]              mode_lat;
  logic [1:0]              mode_eff;
  logic [NUM_CH*ACC_W-1:0] acc;
  logic [NUM_CH*ACC_W-1:0] acc_next;
  logic [ACC_W-1:0]        smp;
  logic [ACC_W-1:0]        cur;
  logic [ACC_W-1:0]        nxt;
  logic                    accept;
  logic                    last;
  logic                    overwrite;

  // The first sample of a window uses the live ratio/mode; later samples use
  // the copies latched at that first sample.
  always_comb begin
    n_in      = (PRESCALER_VALUE == '0) ? ONE : PRESCALER_VALUE;
    n_eff     = (cnt == '0) ? n_in : n_lat;
    mode_eff  = (cnt == '0) ? MODE : mode_lat;
    accept    = (state == COLLECT) && ENABLE && IN_VALID;
    last      = accept && (cnt == (n_eff - ONE));
    overwrite = last && DATA_VALID && !DATA_READY;
    acc_next  = '0;
    smp       = '0;
    cur       = '0;
    nxt       = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      smp = {{RATIO_W{1'b0}}, DATA_IN[c*DATA_W +: DATA_W]};
      cur = acc[c*ACC_W +: ACC_W];
      if (cnt == '0) begin
        nxt = smp;
      end else begin
        case (mode_eff)
          M_SAMPLE: nxt = smp;
          M_MAX:    nxt = (smp > cur) ? smp : cur;
          M_MIN:    nxt = (smp < cur) ? smp : cur;
          default:  nxt = cur + smp;
        endcase
      end
      acc_next[c*ACC_W +: ACC_W] = nxt;
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      n_lat      <= '0;
      mode_lat   <= '0;
      acc        <= '0;
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (ENABLE) state <= COLLECT;
        default: if (!ENABLE) state <= IDLE;
      endcase

      if (!ENABLE) begin
        cnt <= '0;
        acc <= '0;
      end else if (accept) begin
        if (cnt == '0) begin
          n_lat    <= n_in;
          mode_lat <= MODE;
        end
        if (last) begin
          cnt      <= '0;
          acc      <= '0;
          DATA_OUT <= acc_next;
        end else begin
          cnt <= cnt + ONE;
          acc <= acc_next;
        end
      end

      if (last)
        DATA_VALID <= 1'b1;
      else if (DATA_VALID && DATA_READY)
        DATA_VALID <= 1'b0;

      if (overwrite)
        OVERRUN <= 1'b1;
      else if (CLR_OVERRUN)
        OVERRUN <= 1'b0;
    end
  end

`ifdef ADC_DECIM_OVERRUN_CNT_EN
  always_ff @(posedge SYS_CLK) begin
    if (RESET || CLR_OVERRUN)
      OVERRUN_CNT <= '0;
    else if (overwrite && (OVERRUN_CNT != '1))
      OVERRUN_CNT <= OVERRUN_CNT + 16'd1;
  end
`endif

endmodule

// File: tb/tb_adc_multi_decimator.sv
// tb_adc_multi_decimator
//   Directed-vector bench for adc_multi_decimator (default parameters).
//   Inputs change 1 time unit after a rising edge, and outputs are sampled at
//   that same point.
module tb_adc_multi_decimator;

  localparam int NUM_CH  = 2;
  localparam int DATA_W  = 14;
  localparam int RATIO_W = 7;
  localparam int ACC_W   = DATA_W + RATIO_W;

  logic                      clk;
  logic                      rst;
  logic                      enable;
  logic                      in_valid;
  logic [NUM_CH*DATA_W-1:0]  data_in;
  logic [RATIO_W-1:0]        prescaler;
  logic [1:0]                mode;
  logic [NUM_CH*ACC_W-1:0]   data_out;
  logic                      data_valid;
  logic                      data_ready;
  logic                      overrun;
  logic                      clr_overrun;
`ifdef ADC_DECIM_OVERRUN_CNT_EN
  logic [15:0]               overrun_cnt;
`endif

  int unsigned total;
  int unsigned bad;

  adc_multi_decimator #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .RATIO_W(RATIO_W)
  ) dut (
    .SYS_CLK        (clk),
    .RESET          (rst),
    .ENABLE         (enable),
    .IN_VALID       (in_valid),
    .DATA_IN        (data_in),
    .PRESCALER_VALUE(prescaler),
    .MODE           (mode),
    .DATA_OUT       (data_out),
    .DATA_VALID     (data_valid),
    .DATA_READY     (data_ready),
    .OVERRUN        (overrun),
    .CLR_OVERRUN    (clr_overrun)
`ifdef ADC_DECIM_OVERRUN_CNT_EN
    ,
    .OVERRUN_CNT    (overrun_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int unsigned c0, input int unsigned c1);
    in_valid = 1'b1;
    data_in  = {DATA_W'(c1), DATA_W'(c0)};
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  function automatic logic [63:0] ch(input int unsigned c, input logic [NUM_CH*ACC_W-1:0] v);
    return 64'(v[c*ACC_W +: ACC_W]);
  endfunction

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    enable      = 1'b0;
    in_valid    = 1'b0;
    data_in     = '0;
    prescaler   = '0;
    mode        = '0;
    data_ready  = 1'b1;
    clr_overrun = 1'b0;
    tick();
    tick();
    check("rst_valid", 64'(data_valid), 64'd0);
    check("rst_out", 64'(data_out), 64'd0);
    check("rst_ovr", 64'(overrun), 64'd0);
    rst = 1'b0;

    // N=4 SAMPLE ramp: result one cycle after samples 3, 7, 11
    enable    = 1'b1;
    prescaler = 7'd4;
    mode      = 2'd0;
    tick();
    for (int i = 0; i < 12; i++) begin
      send(i, 100 + i);
      check($sformatf("ramp_valid%0d", i), 64'(data_valid), (i % 4 == 3) ? 64'd1 : 64'd0);
      if (i % 4 == 3) begin
        check($sformatf("ramp_ch0_%0d", i), ch(0, data_out), 64'(i));
        check($sformatf("ramp_ch1_%0d", i), ch(1, data_out), 64'(100 + i));
      end
    end

    // N=3 MAX / MIN / SUM, ch0 = 100,7,16383 and ch1 = 5,6,7
    prescaler = 7'd3;
    mode = 2'd1;
    send(100, 5); send(7, 6); send(16383, 7);
    check("max_valid", 64'(data_valid), 64'd1);
    check("max_ch0", ch(0, data_out), 64'd16383);
    check("max_ch1", ch(1, data_out), 64'd7);
    mode = 2'd2;
    send(100, 5); send(7, 6); send(16383, 7);
    check("min_ch0", ch(0, data_out), 64'd7);
    check("min_ch1", ch(1, data_out), 64'd5);
    mode = 2'd3;
    send(100, 5); send(7, 6); send(16383, 7);
    check("sum_ch0", ch(0, data_out), 64'd16490);
    check("sum_ch1", ch(1, data_out), 64'd18);

    // N=0 behaves as N=1: every sample passes through
    prescaler = 7'd0;
    mode = 2'd0;
    send(42, 43);
    check("n0_valid", 64'(data_valid), 64'd1);
    check("n0_ch0", ch(0, data_out), 64'd42);
    send(9, 1);
    check("n0_valid2", 64'(data_valid), 64'd1);
    check("n0_ch0b", ch(0, data_out), 64'd9);

    // Backpressure: the second window overwrites the first
    idle();
    check("drain_valid", 64'(data_valid), 64'd0);
    data_ready = 1'b0;
    prescaler  = 7'd2;
    send(1, 2); send(3, 4);
    check("bp_valid", 64'(data_valid), 64'd1);
    check("bp_first", ch(0, data_out), 64'd3);
    check("bp_no_ovr", 64'(overrun), 64'd0);
    send(5, 6);
    check("bp_stable", ch(0, data_out), 64'd3);
    send(7, 8);
    check("bp_newest", ch(0, data_out), 64'd7);
    check("bp_ovr", 64'(overrun), 64'd1);
`ifdef ADC_DECIM_OVERRUN_CNT_EN
    check("bp_ovr_cnt", 64'(overrun_cnt), 64'd1);
`endif
    clr_overrun = 1'b1;
    idle();
    clr_overrun = 1'b0;
    check("clr_ovr", 64'(overrun), 64'd0);
`ifdef ADC_DECIM_OVERRUN_CNT_EN
    check("clr_ovr_cnt", 64'(overrun_cnt), 64'd0);
`endif
    data_ready = 1'b1;
    idle();
    check("xfer_drop", 64'(data_valid), 64'd0);

    // Mid-window change of ratio/mode applies to the next window only
    prescaler = 7'd4;
    mode = 2'd0;
    send(10, 0); send(20, 0);
    prescaler = 7'd2;
    mode = 2'd3;
    send(30, 0);
    check("chg_pending", 64'(data_valid), 64'd0);
    send(40, 0);
    check("chg_old_valid", 64'(data_valid), 64'd1);
    check("chg_old_mode", ch(0, data_out), 64'd40);
    send(1, 0);
    check("chg_new_wait", 64'(data_valid), 64'd0);
    send(2, 0);
    check("chg_new_sum", ch(0, data_out), 64'd3);

    // Gapped input, then abort: partial window dropped, pending result kept
    data_ready = 1'b0;
    prescaler  = 7'd3;
    mode       = 2'd3;
    send(5, 0); idle(); idle();
    send(6, 0); idle(); idle();
    check("gap_no_result", ch(0, data_out), 64'd3);
    check("gap_valid", 64'(data_valid), 64'd1);
    enable = 1'b0;
    idle();
    enable = 1'b1;
    idle();
    check("abort_kept", ch(0, data_out), 64'd3);
    send(1, 0);
    check("abort_fresh", ch(0, data_out), 64'd3);
    check("abort_no_ovr", 64'(overrun), 64'd0);
    send(2, 0); send(4, 0);
    check("abort_sum", ch(0, data_out), 64'd7);
    check("abort_ovr", 64'(overrun), 64'd1);

    // Reset held 2 cycles mid-window
    prescaler = 7'd2;
    mode = 2'd0;
    send(50, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("mrst_valid", 64'(data_valid), 64'd0);
    check("mrst_out", 64'(data_out), 64'd0);
    check("mrst_ovr", 64'(overrun), 64'd0);
`ifdef ADC_DECIM_OVERRUN_CNT_EN
    check("mrst_ovr_cnt", 64'(overrun_cnt), 64'd0);
`endif
    idle();
    send(60, 0);
    check("mrst_fresh", 64'(data_valid), 64'd0);
    send(61, 0);
    check("mrst_valid2", 64'(data_valid), 64'd1);
    check("mrst_ch0", ch(0, data_out), 64'd61);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
